// File: rtl/microsequencer_pkg.sv
// microsequencer_pkg: state encoding, control store word layout and datapath NOP.
package microsequencer_pkg;
  localparam int MIR_W_DEF  = 28;
  localparam int ADDR_W_DEF = 8;
  localparam int NEXT_LSB   = MIR_W_DEF;
  localparam int NEXT_MSB   = MIR_W_DEF + ADDR_W_DEF - 1;
  localparam int JAMN_BIT   = NEXT_MSB + 1;
  localparam int JAMZ_BIT   = NEXT_MSB + 2;
  localparam int HALT_BIT   = NEXT_MSB + 3;
  localparam logic [MIR_W_DEF-1:0] MIR_NOP = '0;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
endpackage

// File: rtl/microsequencer_control_store.sv
// control_store: writable microprogram memory with a registered read port.
module control_store #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 39
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  // Only the read register is cleared; program contents survive reset.
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/microsequencer.sv
// microsequencer: two-cycle fetch/exec control unit driving the datapath microinstruction.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int MIR_W  = MIR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int WORD_W = MIR_W + ADDR_W + 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              flag_n,
  input  logic              flag_z,
  output logic [MIR_W-1:0]  mir,
  output logic [ADDR_W-1:0] mpc,
  output logic              busy,
  output logic              halted
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] mpc_nx;
  logic [WORD_W-1:0] word;
  logic idle_like, jam;
  assign idle_like = state == IDLE || state == HALT;
  assign jam = (word[JAMZ_BIT] & flag_z) | (word[JAMN_BIT] & flag_n);
  control_store #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_store (
    .clock (clock),
    .reset (reset),
    .we    (prog_we && idle_like),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state == FETCH),
    .raddr (mpc),
    .rdata (word)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      mpc   <= '0;
    end else begin
      state <= state_nx;
      mpc   <= mpc_nx;
    end
  // Jump flags only OR into the MSB of the next address.
  always_comb begin
    state_nx = state;
    mpc_nx   = mpc;
    if (idle_like && start) begin
      state_nx = FETCH;
      mpc_nx   = '0;
    end else if (state == FETCH) begin
      state_nx = EXEC;
    end else if (state == EXEC) begin
      state_nx = word[HALT_BIT] ? HALT : FETCH;
      mpc_nx   = word[HALT_BIT] ? mpc : {word[NEXT_MSB] | jam, word[NEXT_MSB-1:NEXT_LSB]};
    end
  end
  assign mir    = state == EXEC ? word[MIR_W-1:0] : MIR_NOP;
  assign busy   = state == FETCH || state == EXEC;
  assign halted = state == HALT;
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed scoreboard bench for the microsequencer.
module tb_microsequencer;
  typedef struct {
    logic [27:0] mir;
    logic [7:0]  mpc;
    logic        busy, halted, fz, fn, we, st;
  } entry_t;

  logic        clock = 0, reset = 1, start = 0, prog_we = 0, flag_n = 0, flag_z = 0;
  logic [7:0]  prog_addr = 0;
  logic [38:0] prog_data = 0;
  logic [27:0] mir;
  logic [7:0]  mpc;
  logic        busy, halted;
  int          n_chk = 0, n_fail = 0;
  entry_t      sb[$];

  microsequencer dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .flag_n(flag_n), .flag_z(flag_z),
    .mir(mir), .mpc(mpc), .busy(busy), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic logic [38:0] w(logic h, logic jz, logic jn, logic [7:0] nx, logic [27:0] m);
    return {h, jz, jn, nx, m};
  endfunction

  task automatic chk(string tag, logic [39:0] obs, logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [27:0] m, logic [7:0] p, logic b, logic h);
    chk({tag, ".mir"}, 40'(mir), 40'(m));
    chk({tag, ".mpc"}, 40'(mpc), 40'(p));
    chk({tag, ".busy"}, 40'(busy), 40'(b));
    chk({tag, ".halted"}, 40'(halted), 40'(h));
  endtask

  task automatic push(logic [27:0] m, logic [7:0] p, logic b, logic h,
                      logic fz = 0, logic fn = 0, logic we = 0, logic st = 0);
    entry_t e;
    e.mir = m; e.mpc = p; e.busy = b; e.halted = h; e.fz = fz; e.fn = fn; e.we = we; e.st = st;
    sb.push_back(e);
  endtask

  task automatic load(logic [7:0] a, logic [38:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(negedge clock);
    prog_we = 0;
  endtask

  task automatic kick();
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  // Drives each cycle's inputs from the queue and checks the cycle's expected outputs.
  task automatic run(string tag);
    entry_t e;
    int cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      flag_z = e.fz; flag_n = e.fn; start = e.st;
      prog_we = e.we; prog_addr = 8'h01; prog_data = w(1, 0, 0, 8'h00, 28'h77);
      chk_all($sformatf("%s[%0d]", tag, cyc), e.mir, e.mpc, e.busy, e.halted);
      cyc++;
      @(negedge clock);
    end
    flag_z = 0; flag_n = 0; start = 0; prog_we = 0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_all("reset", 28'h0, 8'h00, 0, 0);
    reset = 0;
    @(negedge clock);
    chk_all("idle", 28'h0, 8'h00, 0, 0);

    load(8'h00, w(0, 0, 0, 8'h01, 28'h10));
    load(8'h01, w(1, 0, 0, 8'h00, 28'h20));
    push(0, 8'h00, 1, 0); push(28'h10, 8'h00, 1, 0);
    push(0, 8'h01, 1, 0); push(28'h20, 8'h01, 1, 0, 0, 0, 0, 1);
    push(0, 8'h01, 0, 1);
    kick(); run("linear");

    load(8'h00, w(0, 1, 0, 8'h05, 28'h1));
    load(8'h85, w(1, 0, 0, 8'h00, 28'h85));
    load(8'h05, w(1, 0, 0, 8'h00, 28'h5));
    push(0, 8'h00, 1, 0); push(28'h1, 8'h00, 1, 0, 1);
    push(0, 8'h85, 1, 0); push(28'h85, 8'h85, 1, 0);
    push(0, 8'h85, 0, 1);
    kick(); run("jamz1");
    push(0, 8'h00, 1, 0); push(28'h1, 8'h00, 1, 0, 0);
    push(0, 8'h05, 1, 0); push(28'h5, 8'h05, 1, 0);
    push(0, 8'h05, 0, 1);
    kick(); run("jamz0");

    load(8'h00, w(0, 0, 1, 8'h80, 28'h2));
    load(8'h80, w(1, 0, 0, 8'h00, 28'h80));
    push(0, 8'h00, 1, 0); push(28'h2, 8'h00, 1, 0, 0, 1);
    push(0, 8'h80, 1, 0); push(28'h80, 8'h80, 1, 0);
    push(0, 8'h80, 0, 1);
    kick(); run("jamn_msb");
    load(8'h00, w(0, 0, 1, 8'h05, 28'h3));
    push(0, 8'h00, 1, 0, 1, 1); push(28'h3, 8'h00, 1, 0, 0, 0);
    push(0, 8'h05, 1, 0); push(28'h5, 8'h05, 1, 0);
    push(0, 8'h05, 0, 1);
    kick(); run("flag_fetch");

    load(8'h00, w(0, 0, 0, 8'h01, 28'h10));
    load(8'h01, w(1, 0, 0, 8'h00, 28'h20));
    push(0, 8'h00, 1, 0, 0, 0, 1); push(28'h10, 8'h00, 1, 0, 0, 0, 1);
    push(0, 8'h01, 1, 0, 0, 0, 1); push(28'h20, 8'h01, 1, 0, 0, 0, 1);
    push(0, 8'h01, 0, 1);
    kick(); run("guard_busy");
    push(0, 8'h00, 1, 0); push(28'h10, 8'h00, 1, 0);
    push(0, 8'h01, 1, 0); push(28'h20, 8'h01, 1, 0);
    push(0, 8'h01, 0, 1);
    kick(); run("guard_rerun");
    load(8'h01, w(1, 0, 0, 8'h00, 28'h77));
    push(0, 8'h00, 1, 0); push(28'h10, 8'h00, 1, 0);
    push(0, 8'h01, 1, 0); push(28'h77, 8'h01, 1, 0);
    push(0, 8'h01, 0, 1);
    kick(); run("halt_write");

    push(0, 8'h00, 1, 0); push(28'h10, 8'h00, 1, 0); push(0, 8'h01, 1, 0);
    kick(); run("pre_reset");
    chk_all("exec_before_reset", 28'h77, 8'h01, 1, 0);
    reset = 1;
    #1;
    chk_all("reset_async", 28'h0, 8'h00, 0, 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk_all("post_reset_idle", 28'h0, 8'h00, 0, 0);

    prog_we = 1; prog_addr = 8'h00; prog_data = w(1, 0, 0, 8'h00, 28'h99); start = 1;
    @(negedge clock);
    prog_we = 0; start = 0;
    push(28'h99, 8'h00, 1, 0); push(0, 8'h00, 0, 1);
    chk_all("same_cycle_fetch", 28'h0, 8'h00, 1, 0);
    @(negedge clock);
    run("same_cycle");

    load(8'h00, w(0, 0, 0, 8'h01, 28'h10));
    push(0, 8'h00, 1, 0); push(28'h10, 8'h00, 1, 0);
    push(0, 8'h01, 1, 0); push(28'h77, 8'h01, 1, 0);
    push(0, 8'h01, 0, 1);
    kick(); run("retained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
